// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: default sizes, the
// launch-FSM state type and a small constant helper used by elaboration checks.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH   = 32'd8;
  localparam int unsigned UART_FIFO_DEPTH   = 32'd16;
  localparam int unsigned UART_BUSY_TIMEOUT = 32'd64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_buf_state_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Host-side valid/ready byte handshake into the transmit buffer.
interface uart_tx_buffer_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO holding queued bytes. Occupancy is tracked by an explicit
// level counter so full/empty never depend on pointer comparison. Flush
// overrides any same-cycle push or pop.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned LVL_W     = $clog2(DEPTH + 32'd1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0]      level_o
);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  push_ok_s, pop_ok_s;

  assign push_ok_s = push_i && (level_q != LVL_FULL) && !flush_i;
  assign pop_ok_s  = pop_i && (level_q != {LVL_W{1'b0}}) && !flush_i;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Next pointers and level; pointers wrap naturally because DEPTH is 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      level_d  = {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered transmit front-end: queues host bytes and launches them one at a
// time into the UART transmitter with a start/busy handshake. A launch that
// never sees busy within BUSY_TIMEOUT cycles is abandoned and flagged.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned DEPTH        = UART_FIFO_DEPTH,
  parameter int unsigned BUSY_TIMEOUT = UART_BUSY_TIMEOUT,
  localparam int unsigned LVL_W       = $clog2(DEPTH + 32'd1),
  localparam int unsigned CNT_W       = (BUSY_TIMEOUT > 32'd1) ? $clog2(BUSY_TIMEOUT) : 32'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  flush_i,
  uart_tx_buffer_if.slave       host,
  output logic                  tx_enable_o,
  output logic                  tx_start_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  input  logic                  tx_busy_i,
  output logic [LVL_W-1:0]      level_o,
  output logic                  timeout_err_o
);

  if (!is_pow2(DEPTH) || (DEPTH < 32'd2)) begin : g_bad_depth
    $error("uart_tx_buffer: DEPTH must be a power of two and at least 2");
  end
  if (BUSY_TIMEOUT < 32'd1) begin : g_bad_timeout
    $error("uart_tx_buffer: BUSY_TIMEOUT must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  tx_buf_state_t         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  timeout_set_s;
  logic                  pop_s;
  logic                  push_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [LVL_W-1:0]      level_s;

  assign push_s        = host.in_valid && host.in_ready;
  assign host.in_ready = (level_s != LVL_W'(DEPTH));
  assign tx_enable_o   = enable_i;
  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign level_o       = level_s;
  assign timeout_err_o = timeout_err_q;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_i),
    .wdata_i (host.in_data),
    .rdata_o (head_s),
    .level_o (level_s)
  );

  // Launch FSM: pop on idle, pulse start, wait for busy to rise then fall.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    timeout_set_s = 1'b0;
    pop_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A flush in the same cycle suppresses the pop and keeps us idle.
        if (enable_i && (level_s != {LVL_W{1'b0}}) && !tx_busy_i && !flush_i) begin
          pop_s      = 1'b1;
          tx_data_d  = head_s;
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_set_s = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) state_d = ST_IDLE;
        else            state_d = ST_WAIT_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky timeout flag; flush clears it even if a timeout fires that cycle.
  always_comb begin
    if (flush_i)            timeout_err_d = 1'b0;
    else if (timeout_set_s) timeout_err_d = 1'b1;
    else                    timeout_err_d = timeout_err_q;
  end

  // FSM, launch data, counter and status registers; reset aborts locally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      tx_data_q     <= {DATA_WIDTH{1'b0}};
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
